// File: rtl/seq_det_param.sv
// Serial pattern detector with runtime-loadable pattern and overlap/non-overlap modes.
// Optional saturating match counter built only when SEQ_DET_MATCH_COUNT_EN is defined.
module seq_det_param #(
  parameter int             LEN     = 6,
  parameter logic [LEN-1:0] PATTERN = LEN'(6'b101101),
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(LEN + 1);

  typedef enum logic {FILL, ARMED} state_t;

  state_t         state, state_nxt;
  logic [LEN-1:0] hist, hist_nxt;
  logic [LEN-1:0] pat, pat_nxt;
  logic [LEN-1:0] shifted;
  logic [FW-1:0]  fill, fill_nxt;
  logic           match;
  logic           last_fill_bit;

  assign shifted       = {hist[LEN-2:0], x};
  assign last_fill_bit = (fill == FW'(LEN - 1));

  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    pat_nxt   = pat;
    match     = 1'b0;
    if (pat_load) begin
      pat_nxt   = pat_in;
      hist_nxt  = '0;
      fill_nxt  = '0;
      state_nxt = FILL;
    end else if (en) begin
      // The current bit counts toward the LEN valid bits needed for a match.
      match = ((state == ARMED) || last_fill_bit) && (shifted == pat);
      if (match && !overlap) begin
        hist_nxt  = '0;
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        hist_nxt = shifted;
        if (state == FILL) begin
          fill_nxt = fill + FW'(1);
          if (last_fill_bit) state_nxt = ARMED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      hist  <= '0;
      fill  <= '0;
      pat   <= PATTERN;
      y     <= 1'b0;
    end else begin
      state <= state_nxt;
      hist  <= hist_nxt;
      fill  <= fill_nxt;
      pat   <= pat_nxt;
      y     <= match;
    end
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || pat_load) begin
      cnt <= '0;
    end else if (match && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed literal cases plus randomized traffic against a queue-based model.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic       en = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [5:0] pat_in = 6'b0;
  logic       y1, y2;
  logic [7:0] mc1;
  logic [1:0] mc2;

`ifdef SEQ_DET_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_det_param dut (
    .clk(clk), .rst(rst), .x(x), .en(en), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .y(y1), .match_count(mc1)
  );

  seq_det_param #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .x(x), .en(en), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .y(y2), .match_count(mc2)
  );

  int nchk = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the bits received since the last clear, oldest first, capped at 6.
  bit       q[$];
  bit [5:0] pat_m = 6'b101101;
  bit       exp_y = 1'b0;
  int       exp_c1 = 0;
  int       exp_c2 = 0;

  function automatic bit q_match();
    if (q.size() != 6) return 1'b0;
    for (int i = 0; i < 6; i++)
      if (q[i] != pat_m[5-i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      pat_m = 6'b101101;
      exp_y = 1'b0;
      exp_c1 = 0;
      exp_c2 = 0;
    end else if (pat_load) begin
      q.delete();
      pat_m = pat_in;
      exp_y = 1'b0;
      exp_c1 = 0;
      exp_c2 = 0;
    end else if (en) begin
      q.push_back(x);
      if (q.size() > 6) void'(q.pop_front());
      exp_y = q_match();
      if (exp_y) begin
        if (exp_c1 < 255) exp_c1++;
        if (exp_c2 < 3) exp_c2++;
        if (!overlap) q.delete();
      end
    end else begin
      exp_y = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_y", y1, exp_y);
      check("model_y_w2", y2, exp_y);
      check("model_count", mc1, CNT_EN ? exp_c1 : 0);
      check("model_count_w2", mc2, CNT_EN ? exp_c2 : 0);
    end
  end

  task automatic drive(input logic r, input logic e, input logic xb, input logic ov,
                       input logic pl, input logic [5:0] pi);
    @(negedge clk);
    rst = r; en = e; x = xb; overlap = ov; pat_load = pl; pat_in = pi;
    @(posedge clk);
    #1;
  endtask

  // Bits are sent MSB first; ymask marks the bits after which y must pulse.
  task automatic feed(input logic [31:0] bits, input int n, input logic ov,
                      input logic [31:0] ymask, input string nm);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, bits[n-1-i], ov, 1'b0, 6'b0);
      check(nm, y1, ymask[n-1-i]);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b0);
  endtask

  initial begin
    do_reset();
    check("reset_y", y1, 0);
    check("reset_count", mc1, 0);
    check("reset_count_w2", mc2, 0);
    chk_on = 1'b1;

    feed(32'b101101101, 9, 1'b1, 32'b000001001, "overlap_stream");
    check("overlap_count", mc1, CNT_EN ? 2 : 0);

    do_reset();
    feed(32'b101101101, 9, 1'b0, 32'b000001000, "nonoverlap_stream");
    check("nonoverlap_count", mc1, CNT_EN ? 1 : 0);

    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b111000);
    check("load_y", y1, 0);
    feed(32'b111000, 6, 1'b1, 32'b000001, "new_pattern");
    feed(32'b101101, 6, 1'b1, 32'b000000, "old_pattern");
    check("load_count", mc1, CNT_EN ? 1 : 0);

    do_reset();
    feed(32'b10110, 5, 1'b1, 32'b0, "pre_stall");
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b0);
      check("stall_y", y1, 0);
    end
    feed(32'b1, 1, 1'b1, 32'b1, "post_stall");

    do_reset();
    feed(32'b10110, 5, 1'b1, 32'b0, "pre_reset");
    do_reset();
    check("mid_reset_y", y1, 0);
    feed(32'b1, 1, 1'b1, 32'b0, "post_reset");

    do_reset();
    feed(32'b101101101101101101, 18, 1'b1, 32'b000001001001001001, "sat_stream");
    check("sat_count_w2", mc2, CNT_EN ? 3 : 0);
    check("sat_count", mc1, CNT_EN ? 5 : 0);

    for (int c = 0; c < 4000; c++) begin
      logic [5:0] pi;
      case ($urandom_range(0, 3))
        0: pi = 6'b101101;
        1: pi = 6'b111000;
        2: pi = 6'b010101;
        default: pi = 6'($urandom);
      endcase
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85, 1'($urandom),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) == 0, pi);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
